// File: rtl/audio_pkg.sv
// Shared audio-path definitions: I2S frame geometry and the transmitter state encoding.
package audio_pkg;

    localparam int unsigned DEF_SAMPLE_W = 18;
    localparam int unsigned SLOTS_PER_CH = 32;
    localparam int unsigned FRAME_SLOTS  = 64;
    localparam int unsigned SLOT_W       = $clog2(FRAME_SLOTS);
    localparam int unsigned CH_IDX_W     = $clog2(SLOTS_PER_CH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Word select for a slot: upper half of the frame is the right channel.
    function automatic logic slot_is_right(input logic [SLOT_W-1:0] slot);
        return slot[SLOT_W-1];
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock generator: divides clk into a registered bclk and flags falling toggles.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_HALF = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bclk,
    output logic fall_en_c
);

    localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap_c;

    assign wrap_c    = (div_cnt == DIV_LAST);
    // The toggle about to happen is a fall when bclk is currently high.
    assign fall_en_c = en && wrap_c && bclk;

    // Half-period divider; clr realigns the phase at the start of a frame from idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (clr) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (en) begin
            if (wrap_c) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: captures a stereo pair per tick48k and shifts it out as a 64-slot frame.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
    parameter int unsigned DAC_W     = 16,
    parameter int unsigned BCLK_HALF = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick48k,
    input  logic [SAMPLE_W-1:0] sound_l,
    input  logic [SAMPLE_W-1:0] sound_r,
    output logic                bclk,
    output logic                lrck,
    output logic                sdata,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [DAC_W-1:0]  sh_l;
    logic [DAC_W-1:0]  sh_r;
    logic [DAC_W-1:0]  pend_l;
    logic [DAC_W-1:0]  pend_r;
    logic              pending;

    logic [DAC_W-1:0]    tick_l_c;
    logic [DAC_W-1:0]    tick_r_c;
    logic [DAC_W-1:0]    start_l_c;
    logic [DAC_W-1:0]    start_r_c;
    logic                fall_en_c;
    logic                run_c;
    logic                idle_start_c;
    logic                frame_end_c;
    logic                start_c;
    logic [SLOT_W-1:0]   next_slot_c;
    logic [CH_IDX_W-1:0] ch_idx_c;
    logic                right_c;
    logic                data_slot_c;

    // Truncate to the DAC width: keep the MSBs, drop the LSBs.
    assign tick_l_c = sound_l[SAMPLE_W-1 -: DAC_W];
    assign tick_r_c = sound_r[SAMPLE_W-1 -: DAC_W];

    generate
        if (SAMPLE_W > DAC_W) begin : g_trunc
            logic unused_lsb_c;
            assign unused_lsb_c = ^{sound_l[SAMPLE_W-DAC_W-1:0], sound_r[SAMPLE_W-DAC_W-1:0]};
        end
    endgenerate

    assign run_c        = (state == SHIFT);
    assign idle_start_c = (state == IDLE) && tick48k;
    assign frame_end_c  = fall_en_c && (slot == SLOT_W'(FRAME_SLOTS - 1));
    // A new frame begins from idle on a tick, or back-to-back when a pair is waiting.
    assign start_c      = idle_start_c || (frame_end_c && (tick48k || pending));
    // A tick on the start edge wins over the pending pair.
    assign start_l_c    = tick48k ? tick_l_c : pend_l;
    assign start_r_c    = tick48k ? tick_r_c : pend_r;

    // Slot entered on this falling toggle; index 0 of each half is the one-bit I2S delay.
    assign next_slot_c = slot + SLOT_W'(1);
    assign ch_idx_c    = next_slot_c[CH_IDX_W-1:0];
    assign right_c     = slot_is_right(next_slot_c);
    assign data_slot_c = (ch_idx_c != '0) && (32'(ch_idx_c) <= DAC_W);

    i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (idle_start_c),
        .en        (run_c),
        .bclk      (bclk),
        .fall_en_c (fall_en_c)
    );

    // Frame FSM, slot counter, serializer and registered I2S outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= '0;
            lrck       <= 1'b1;
            sdata      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sh_l       <= '0;
            sh_r       <= '0;
        end else begin
            frame_done <= frame_end_c;
            if (start_c) begin
                state <= SHIFT;
                slot  <= '0;
                lrck  <= 1'b0;
                sdata <= 1'b0;
                busy  <= 1'b1;
                sh_l  <= start_l_c;
                sh_r  <= start_r_c;
            end else if (frame_end_c) begin
                state <= IDLE;
                slot  <= '0;
                lrck  <= 1'b1;
                sdata <= 1'b0;
                busy  <= 1'b0;
            end else if (run_c && fall_en_c) begin
                slot <= next_slot_c;
                lrck <= right_c;
                if (data_slot_c) begin
                    if (right_c) begin
                        sdata <= sh_r[DAC_W-1];
                        sh_r  <= {sh_r[DAC_W-2:0], 1'b0};
                    end else begin
                        sdata <= sh_l[DAC_W-1];
                        sh_l  <= {sh_l[DAC_W-2:0], 1'b0};
                    end
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

    // Pending pair for ticks that arrive mid-frame; overwriting or discarding it flags overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            pend_l  <= '0;
            pend_r  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (run_c) begin
                if (frame_end_c) begin
                    pending <= 1'b0;
                    overrun <= tick48k && pending;
                end else if (tick48k) begin
                    pend_l  <= tick_l_c;
                    pend_r  <= tick_r_c;
                    pending <= 1'b1;
                    overrun <= pending;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: default timing (instance a) and BCLK_HALF=4 (instance b).
module tb_i2s_dac_tx;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, tick_a, bclk_a, lrck_a, sdata_a, busy_a, fd_sig_a, ovr_sig_a;
    logic [17:0] sl_a, sr_a;
    logic        rst_b, tick_b, bclk_b, lrck_b, sdata_b, busy_b, fd_sig_b, ovr_sig_b;
    logic [17:0] sl_b, sr_b;

    int n_chk = 0;
    int n_fail = 0;

    pair_t q_a[$];
    pair_t q_b[$];

    i2s_dac_tx #(.SAMPLE_W(18), .DAC_W(16), .BCLK_HALF(15)) dut_a (
        .clk(clk), .rst(rst_a), .tick48k(tick_a), .sound_l(sl_a), .sound_r(sr_a),
        .bclk(bclk_a), .lrck(lrck_a), .sdata(sdata_a), .busy(busy_a),
        .frame_done(fd_sig_a), .overrun(ovr_sig_a)
    );

    i2s_dac_tx #(.SAMPLE_W(18), .DAC_W(16), .BCLK_HALF(4)) dut_b (
        .clk(clk), .rst(rst_b), .tick48k(tick_b), .sound_l(sl_b), .sound_r(sr_b),
        .bclk(bclk_b), .lrck(lrck_b), .sdata(sdata_b), .busy(busy_b),
        .frame_done(fd_sig_b), .overrun(ovr_sig_b)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected slot pattern, slot 0 in the MSB.
    function automatic logic [63:0] frame_bits(input pair_t p);
        return {1'b0, p.l, 15'b0, 1'b0, p.r, 15'b0};
    endfunction

    localparam logic [63:0] LRCK_PAT = 64'h00000000_FFFFFFFF;

    // Monitor a: collect sdata/lrck at each bclk rise, score a frame at each frame_done.
    int          nr_a = 0, fd_a = 0, ov_a = 0, low_a = 0;
    logic        watch_a = 1'b0, prev_a = 1'b0;
    logic [63:0] bits_a = '0, lr_a = '0;
    always @(negedge clk) begin
        if (rst_a) begin
            nr_a = 0; bits_a = '0; lr_a = '0;
        end else begin
            if (bclk_a && !prev_a) begin
                if (nr_a < 64) begin
                    bits_a[63-nr_a] = sdata_a;
                    lr_a[63-nr_a]   = lrck_a;
                end
                nr_a++;
            end
            if (watch_a && !busy_a) low_a++;
            if (ovr_sig_a) ov_a++;
            if (fd_sig_a) begin
                fd_a++;
                if (q_a.size() == 0) begin
                    chk("a_unexpected_frame_done", 64'(fd_sig_a), 64'd0);
                end else begin
                    pair_t e;
                    e = q_a.pop_front();
                    chk("a_frame_slots", 64'(nr_a), 64'd64);
                    chk("a_frame_sdata", bits_a, frame_bits(e));
                    chk("a_frame_lrck", lr_a, LRCK_PAT);
                end
                nr_a = 0; bits_a = '0; lr_a = '0;
            end
        end
        prev_a = bclk_a;
    end

    // Monitor b: same scoreboard for the fast-bclk instance.
    int          nr_b = 0, fd_b = 0, ov_b = 0;
    logic        prev_b = 1'b0;
    logic [63:0] bits_b = '0, lr_b = '0;
    always @(negedge clk) begin
        if (rst_b) begin
            nr_b = 0; bits_b = '0; lr_b = '0;
        end else begin
            if (bclk_b && !prev_b) begin
                if (nr_b < 64) begin
                    bits_b[63-nr_b] = sdata_b;
                    lr_b[63-nr_b]   = lrck_b;
                end
                nr_b++;
            end
            if (ovr_sig_b) ov_b++;
            if (fd_sig_b) begin
                fd_b++;
                if (q_b.size() == 0) begin
                    chk("b_unexpected_frame_done", 64'(fd_sig_b), 64'd0);
                end else begin
                    pair_t e;
                    e = q_b.pop_front();
                    chk("b_frame_slots", 64'(nr_b), 64'd64);
                    chk("b_frame_sdata", bits_b, frame_bits(e));
                    chk("b_frame_lrck", lr_b, LRCK_PAT);
                end
                nr_b = 0; bits_b = '0; lr_b = '0;
            end
        end
        prev_b = bclk_b;
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Tick seen at the next posedge (E0); returns at the negedge after E0.
    task automatic pulse_a(input logic [17:0] l, input logic [17:0] r);
        tick_a = 1'b1; sl_a = l; sr_a = r;
        @(negedge clk);
        tick_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [17:0] l, input logic [17:0] r);
        tick_b = 1'b1; sl_b = l; sr_b = r;
        @(negedge clk);
        tick_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ov0, fd0;
        rst_a = 1'b1; tick_a = 1'b0; sl_a = '0; sr_a = '0;
        rst_b = 1'b1; tick_b = 1'b0; sl_b = '0; sr_b = '0;
        adv(3);
        chk("reset_bclk", 64'(bclk_a), 64'd0);
        chk("reset_lrck", 64'(lrck_a), 64'd1);
        chk("reset_sdata", 64'(sdata_a), 64'd0);
        chk("reset_busy", 64'(busy_a), 64'd0);
        chk("reset_frame_done", 64'(fd_sig_a), 64'd0);
        chk("reset_overrun", 64'(ovr_sig_a), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        adv(3);

        // Single frame with alternating bit patterns.
        pulse_a(18'h2AAAA, 18'h15555);
        q_a.push_back('{l: 16'hAAAA, r: 16'h5555});
        chk("e0_lrck", 64'(lrck_a), 64'd0);
        chk("e0_busy", 64'(busy_a), 64'd1);
        adv(14);
        chk("bclk_before_rise", 64'(bclk_a), 64'd0);
        adv(1);
        chk("bclk_rise_e0p15", 64'(bclk_a), 64'd1);
        adv(944);
        chk("lrck_e0p959", 64'(lrck_a), 64'd0);
        adv(1);
        chk("lrck_e0p960", 64'(lrck_a), 64'd1);
        adv(959);
        chk("fd_e0p1919", 64'(fd_sig_a), 64'd0);
        adv(1);
        chk("fd_e0p1920", 64'(fd_sig_a), 64'd1);
        chk("busy_e0p1920", 64'(busy_a), 64'd0);
        chk("lrck_idle", 64'(lrck_a), 64'd1);
        adv(5);

        // Negative full-scale and LSB truncation.
        pulse_a(18'h3FFFF, 18'h20003);
        q_a.push_back('{l: 16'hFFFF, r: 16'h8000});
        adv(1920);
        chk("trunc_busy_end", 64'(busy_a), 64'd0);
        adv(5);

        // Back-to-back: tick mid-frame becomes the next frame with no idle gap.
        ov0 = ov_a;
        pulse_a(18'h12344, 18'h3C000);
        q_a.push_back('{l: 16'h48D1, r: 16'hF000});
        watch_a = 1'b1; low_a = 0;
        adv(999);
        pulse_a(18'h00004, 18'h3FFFC);
        q_a.push_back('{l: 16'h0001, r: 16'hFFFF});
        adv(920);
        chk("b2b_fd", 64'(fd_sig_a), 64'd1);
        chk("b2b_lrck", 64'(lrck_a), 64'd0);
        chk("b2b_busy", 64'(busy_a), 64'd1);
        chk("b2b_bclk_low", 64'(bclk_a), 64'd0);
        adv(15);
        chk("b2b_bclk_rise", 64'(bclk_a), 64'd1);
        adv(1904);
        watch_a = 1'b0;
        adv(1);
        chk("b2b_fd2", 64'(fd_sig_a), 64'd1);
        chk("b2b_busy_end", 64'(busy_a), 64'd0);
        chk("b2b_busy_never_low", 64'(low_a), 64'd0);
        chk("b2b_no_overrun", 64'(ov_a - ov0), 64'd0);
        adv(5);

        // Overrun: second mid-frame tick overwrites the first.
        ov0 = ov_a;
        pulse_a(18'h01000, 18'h02000);
        q_a.push_back('{l: 16'h0400, r: 16'h0800});
        adv(299);
        pulse_a(18'h11110, 18'h22220);
        chk("ovr_first_pending", 64'(ovr_sig_a), 64'd0);
        adv(599);
        pulse_a(18'h33330, 18'h0CCCC);
        q_a.push_back('{l: 16'hCCCC, r: 16'h3333});
        chk("ovr_pulse", 64'(ovr_sig_a), 64'd1);
        adv(1);
        chk("ovr_one_cycle", 64'(ovr_sig_a), 64'd0);
        adv(2939);
        chk("ovr_busy_end", 64'(busy_a), 64'd0);
        chk("ovr_count", 64'(ov_a - ov0), 64'd1);
        adv(5);

        // Asynchronous reset in the middle of a frame.
        pulse_a(18'h3FFFF, 18'h3FFFF);
        adv(500);
        #2 rst_a = 1'b1;
        #1;
        chk("mid_rst_bclk", 64'(bclk_a), 64'd0);
        chk("mid_rst_lrck", 64'(lrck_a), 64'd1);
        chk("mid_rst_sdata", 64'(sdata_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        fd0 = fd_a;
        adv(2);
        rst_a = 1'b0;
        adv(2500);
        chk("mid_rst_no_frame_done", 64'(fd_a - fd0), 64'd0);
        chk("mid_rst_idle", 64'(busy_a), 64'd0);

        // BCLK_HALF=4: bclk period and a tick exactly on the frame-end edge.
        pulse_b(18'h2AAAA, 18'h15555);
        q_b.push_back('{l: 16'hAAAA, r: 16'h5555});
        adv(3);
        chk("fast_bclk_e0p3", 64'(bclk_b), 64'd0);
        adv(1);
        chk("fast_bclk_e0p4", 64'(bclk_b), 64'd1);
        adv(4);
        chk("fast_bclk_e0p8", 64'(bclk_b), 64'd0);
        adv(503);
        chk("fast_fd_e0p511", 64'(fd_sig_b), 64'd0);
        pulse_b(18'h3FFFF, 18'h20003);
        q_b.push_back('{l: 16'hFFFF, r: 16'h8000});
        chk("fast_fd_e0p512", 64'(fd_sig_b), 64'd1);
        chk("fast_edge_busy", 64'(busy_b), 64'd1);
        chk("fast_edge_lrck", 64'(lrck_b), 64'd0);
        chk("fast_edge_no_overrun", 64'(ovr_sig_b), 64'd0);
        adv(512);
        chk("fast_fd2", 64'(fd_sig_b), 64'd1);
        chk("fast_busy_end", 64'(busy_b), 64'd0);
        adv(5);

        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
        chk("b_overrun_total", 64'(ov_b), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
